// File: rtl/mem_write_checker.sv
// Data-memory write-bus monitor: matches observed writes against a programmable
// table of expected writes and holds a sticky PASS / FAIL / TIMEOUT verdict.
module mem_write_checker #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_EXP    = 4,
  parameter int unsigned IGN_ADDR = 96,
  parameter int unsigned TIMEOUT  = 200,
  parameter int unsigned ORDERED  = 1,
  localparam int unsigned IDX_W   = (N_EXP > 1) ? $clog2(N_EXP) : 1,
  localparam int unsigned CNT_W   = $clog2(N_EXP) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [CNT_W-1:0]  num_exp,
  input  logic              ign_en,
  input  logic              start,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [15:0]       cyc_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TOUT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   tab_addr_q [N_EXP];
  logic [DATA_W-1:0]   tab_data_q [N_EXP];
  logic [N_EXP-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0]    num_q, num_d, num_clamp;
  logic                ign_q, ign_d;
  logic [CNT_W-1:0]    match_q, match_d;
  logic [15:0]         cyc_q, cyc_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic                busy_q, done_q, pass_q, fail_q, tout_q;
  logic                busy_d, done_d, pass_d, fail_d, tout_d;
  logic                found;
  logic                cand;

  assign num_clamp = (num_exp > CNT_W'(N_EXP)) ? CNT_W'(N_EXP) : num_exp;

  // Next-state: start wins, then write verdict, then cycle budget.
  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    num_d       = num_q;
    ign_d       = ign_q;
    match_d     = match_q;
    cyc_d       = cyc_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    found       = 1'b0;
    cand        = 1'b0;

    if (start) begin
      num_d       = num_clamp;
      ign_d       = ign_en;
      match_d     = '0;
      cyc_d       = '0;
      hit_d       = '0;
      fail_addr_d = '0;
      fail_data_d = '0;
      state_d     = (num_clamp == '0) ? PASS : RUN;
    end else if (state_q == RUN) begin
      if (MemWrite) begin
        for (int i = 0; i < N_EXP; i++) begin
          if (ORDERED != 0) cand = (CNT_W'(i) == match_q);
          else              cand = (CNT_W'(i) < num_q) && !hit_q[i];
          if (!found && cand && tab_addr_q[i] == Adr && tab_data_q[i] == WriteData) begin
            found    = 1'b1;
            hit_d[i] = 1'b1;
          end
        end
        if (found) begin
          match_d = match_q + CNT_W'(1);
          if (match_d == num_q) state_d = PASS;
        end else if (!(ign_q && Adr == ADDR_W'(IGN_ADDR))) begin
          state_d     = FAIL;
          fail_addr_d = Adr;
          fail_data_d = WriteData;
        end
      end
      if (state_d == RUN) begin
        if (cyc_q == 16'(TIMEOUT - 1)) state_d = TOUT;
        else                           cyc_d   = cyc_q + 16'd1;
      end
    end

    busy_d = (state_d == RUN);
    pass_d = (state_d == PASS);
    fail_d = (state_d == FAIL);
    tout_d = (state_d == TOUT);
    done_d = pass_d || fail_d || tout_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hit_q       <= '0;
      num_q       <= '0;
      ign_q       <= 1'b0;
      match_q     <= '0;
      cyc_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      tout_q      <= 1'b0;
      for (int i = 0; i < N_EXP; i++) begin
        tab_addr_q[i] <= '0;
        tab_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      num_q       <= num_d;
      ign_q       <= ign_d;
      match_q     <= match_d;
      cyc_q       <= cyc_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      tout_q      <= tout_d;
      // Table is frozen while a run is in progress.
      if (cfg_we && state_q != RUN) begin
        tab_addr_q[cfg_idx] <= cfg_addr;
        tab_data_q[cfg_idx] <= cfg_data;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = tout_q;
  assign match_cnt = match_q;
  assign cyc_cnt   = cyc_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: an ordered and an unordered instance
// share all inputs; expected snapshots are queued and compared after each step.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic [2:0]  num_exp;
  logic        ign_en, start, MemWrite;
  logic [31:0] Adr, WriteData;

  logic        busy_w [2];
  logic        done_w [2];
  logic        pass_w [2];
  logic        fail_w [2];
  logic        tout_w [2];
  logic [2:0]  mcnt_w [2];
  logic [15:0] cyc_w  [2];
  logic [31:0] fa_w   [2];
  logic [31:0] fd_w   [2];

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_BUSY = 5'b10000;
  localparam logic [4:0] F_PASS = 5'b01100;
  localparam logic [4:0] F_FAIL = 5'b01010;
  localparam logic [4:0] F_TOUT = 5'b01001;

  typedef struct {
    string       tag;
    int          dut;
    logic [4:0]  flg;
    logic [2:0]  mc;
    logic [31:0] fa;
    logic [31:0] fd;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_write_checker #(.ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .num_exp(num_exp),
    .ign_en(ign_en), .start(start), .MemWrite(MemWrite), .Adr(Adr),
    .WriteData(WriteData), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .fail(fail_w[1]), .timeout(tout_w[1]),
    .match_cnt(mcnt_w[1]), .cyc_cnt(cyc_w[1]), .fail_addr(fa_w[1]),
    .fail_data(fd_w[1])
  );

  mem_write_checker #(.ORDERED(0)) u_unord (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .num_exp(num_exp),
    .ign_en(ign_en), .start(start), .MemWrite(MemWrite), .Adr(Adr),
    .WriteData(WriteData), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .fail(fail_w[0]), .timeout(tout_w[0]),
    .match_cnt(mcnt_w[0]), .cyc_cnt(cyc_w[0]), .fail_addr(fa_w[0]),
    .fail_data(fd_w[0])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_push(input string tag, input int d, input logic [4:0] flg,
                             input logic [2:0] mc, input logic [31:0] fa,
                             input logic [31:0] fd, input int cyc);
    exp_t e;
    e.tag = tag; e.dut = d; e.flg = flg; e.mc = mc; e.fa = fa; e.fd = fd; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".flags"}, 64'({busy_w[e.dut], done_w[e.dut], pass_w[e.dut],
                                  fail_w[e.dut], tout_w[e.dut]}), 64'(e.flg));
      chk({e.tag, ".match_cnt"}, 64'(mcnt_w[e.dut]), 64'(e.mc));
      chk({e.tag, ".fail_addr"}, 64'(fa_w[e.dut]), 64'(e.fa));
      chk({e.tag, ".fail_data"}, 64'(fd_w[e.dut]), 64'(e.fd));
      if (e.cyc >= 0) chk({e.tag, ".cyc_cnt"}, 64'(cyc_w[e.dut]), 64'(e.cyc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [2:0] n, input logic ign);
    start = 1'b1; num_exp = n; ign_en = ign;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Adr = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    num_exp = '0; ign_en = 1'b0; start = 1'b0; MemWrite = 1'b0; Adr = '0; WriteData = '0;
    tick(); tick();
    expect_push("reset_ord", 1, F_IDLE, 0, 0, 0, 0);
    expect_push("reset_unord", 0, F_IDLE, 0, 0, 0, 0);
    sb_drain();
    reset = 1'b0;
    tick();

    // single expected write with tolerated scratch traffic
    cfg(0, 100, 7);
    go(1, 1);
    expect_push("single.start", 1, F_BUSY, 0, 0, 0, 0); sb_drain();
    wr(96, 3);
    expect_push("single.ign1", 1, F_BUSY, 0, 0, 0, 1); sb_drain();
    wr(96, 5);
    expect_push("single.ign2", 1, F_BUSY, 0, 0, 0, 2); sb_drain();
    wr(100, 7);
    expect_push("single.pass", 1, F_PASS, 1, 0, 0, 2); sb_drain();

    // unexpected write, then verdict stays sticky
    go(1, 1);
    wr(104, 7);
    expect_push("unexp.fail", 1, F_FAIL, 0, 104, 7, 0); sb_drain();
    wr(100, 7);
    expect_push("unexp.sticky", 1, F_FAIL, 0, 104, 7, 0); sb_drain();

    // ordered vs unordered
    cfg(1, 104, 9);
    go(2, 1);
    wr(104, 9);
    expect_push("order.ord_fail", 1, F_FAIL, 0, 104, 9, -1);
    expect_push("order.unord_hit", 0, F_BUSY, 1, 0, 0, 1);
    sb_drain();
    wr(100, 7);
    expect_push("order.unord_pass", 0, F_PASS, 2, 0, 0, 1);
    expect_push("order.ord_sticky", 1, F_FAIL, 0, 104, 9, -1);
    sb_drain();
    go(2, 1);
    wr(104, 9);
    wr(104, 9);
    expect_push("order.dup_fail", 0, F_FAIL, 1, 104, 9, -1); sb_drain();

    // timeout, and a deciding write on the last budgeted cycle
    go(1, 1);
    repeat (199) tick();
    expect_push("tout.last_run", 1, F_BUSY, 0, 0, 0, 199); sb_drain();
    tick();
    expect_push("tout.hit", 1, F_TOUT, 0, 0, 0, 199); sb_drain();
    repeat (5) tick();
    expect_push("tout.frozen", 1, F_TOUT, 0, 0, 0, 199); sb_drain();
    go(1, 1);
    repeat (199) tick();
    wr(100, 7);
    expect_push("tout.edge_pass", 1, F_PASS, 1, 0, 0, 199); sb_drain();

    // restart mid-run, then asynchronous reset mid-run
    go(2, 1);
    wr(100, 7);
    expect_push("restart.before", 1, F_BUSY, 1, 0, 0, 1); sb_drain();
    go(2, 1);
    expect_push("restart.cleared", 1, F_BUSY, 0, 0, 0, 0); sb_drain();
    tick();
    reset = 1'b1;
    #2;
    expect_push("reset.async_ord", 1, F_IDLE, 0, 0, 0, 0);
    expect_push("reset.async_unord", 0, F_IDLE, 0, 0, 0, 0);
    sb_drain();
    tick();
    reset = 1'b0;
    tick();
    go(1, 1);
    wr(100, 7);
    expect_push("reset.table_cleared", 1, F_FAIL, 0, 100, 7, -1); sb_drain();
    cfg(0, 100, 7);
    go(1, 1);
    wr(100, 7);
    expect_push("reset.reload_pass", 1, F_PASS, 1, 0, 0, -1); sb_drain();

    // num_exp = 0 passes immediately
    go(0, 1);
    expect_push("zero.pass", 1, F_PASS, 0, 0, 0, 0); sb_drain();

    // num_exp above capacity clamps to a full table
    for (int i = 0; i < 4; i++) cfg(2'(i), 32'(200 + 4 * i), 32'(i));
    go(7, 1);
    for (int i = 0; i < 3; i++) wr(32'(200 + 4 * i), 32'(i));
    expect_push("clamp.partial", 1, F_BUSY, 3, 0, 0, -1); sb_drain();
    wr(212, 3);
    expect_push("clamp.pass", 1, F_PASS, 4, 0, 0, -1); sb_drain();

    // table write during a run is ignored
    go(1, 1);
    cfg(0, 300, 1);
    wr(300, 1);
    expect_push("cfg_in_run.fail", 1, F_FAIL, 0, 300, 1, -1); sb_drain();

    // ignore window disabled
    go(1, 0);
    expect_push("noign.start", 1, F_BUSY, 0, 0, 0, 0); sb_drain();
    wr(96, 1);
    expect_push("noign.fail", 1, F_FAIL, 0, 96, 1, -1); sb_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
